// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_ctrl_pkg;

  // EX-stage forwarding mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ResultSrcE encoding that marks a load in EX
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Data-memory wait-state FSM
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_forward_unit.sv
// rtl/pipe_hazard_ctrl_forward_unit.sv - EX-stage operand forwarding select for one source register
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardE
);

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded
  always_comb begin
    ForwardE = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
      ForwardE = FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
      ForwardE = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding control and memory wait-state FSM for a 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemBusy,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // The wait counter only has to reach MEM_TIMEOUT-1 before the FSM leaves WAIT
  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_t        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_busy;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_lw_stall;
  logic w_mem_stall;
  logic w_stall_fd;
  logic w_flush_d;
  logic w_flush_e;

  forward_unit u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardAE)
  );

  forward_unit u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (ForwardBE)
  );

  // Hazard detection: load-use in ID/EX and any unfinished memory access in MEM
  always_comb begin
    w_lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
    w_mem_stall = 1'b0;
    case (r_state)
      IDLE:    w_mem_stall = MemReqM && !MemReadyM;
      WAIT:    w_mem_stall = !MemReadyM;
      ERR:     w_mem_stall = 1'b1;
      default: w_mem_stall = 1'b1;
    endcase
  end

  // A memory freeze holds the branch in EX, so its flush is deferred to the release cycle
  always_comb begin
    w_stall_fd = w_lw_stall || w_mem_stall;
    w_flush_d  = PCSrcE && !w_mem_stall;
    w_flush_e  = (w_lw_stall || PCSrcE) && !w_mem_stall;
  end

  assign StallF   = w_stall_fd;
  assign StallD   = w_stall_fd;
  assign StallE   = w_mem_stall;
  assign StallM   = w_mem_stall;
  assign FlushW   = w_mem_stall;
  assign FlushD   = w_flush_d;
  assign FlushE   = w_flush_e;
  assign MemBusy  = r_mem_busy;
  assign MemErr   = r_mem_err;
  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

  // Memory wait-state FSM with registered busy/error flags; ERR holds until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_mem_busy <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (MemReqM && !MemReadyM) begin
            r_state    <= WAIT;
            r_mem_busy <= 1'b1;
          end
        end
        WAIT: begin
          if (MemReadyM) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_mem_busy <= 1'b0;
          end else if (r_wait_cnt == WCNT_LAST) begin
            r_state   <= ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        ERR: begin
          r_mem_busy <= 1'b1;
          r_mem_err  <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
          r_mem_busy <= 1'b0;
          r_mem_err  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters: stop at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_fd && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
